branch_unit_bht: RTL and testbench

//  Parametrised branch resolution unit with a 2-bit saturating-counter branch history table (BHT).

---
 rtl/branch_unit_bht_if.sv | 34 +++
 rtl/branch_unit_bht.sv | 67 ++++++
 tb/tb_branch_unit_bht.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/branch_unit_bht_if.sv
// branch_unit_bht_if: predict/resolve/stat bundle between the pipeline and branch_unit_bht
// master: pipeline side (drives PCs, operands, control); slave: branch unit side
interface branch_unit_bht_if #(
  parameter int XLEN   = 32,
  parameter int STAT_W = 32
);
  logic [XLEN-1:0]   pred_pc_i;
  logic              pred_taken_o;
  logic              resolve_valid_i;
  logic              is_b_type_ctl_i;
  logic [2:0]        instr_func3_ctl_i;
  logic [XLEN-1:0]   resolve_pc_i;
  logic              pred_taken_i;
  logic [XLEN-1:0]   opr_a_i;
  logic [XLEN-1:0]   opr_b_i;
  logic              branch_taken_o;
  logic              mispredict_o;
  logic              resolve_valid_o;
  logic              illegal_func3_o;
  logic [STAT_W-1:0] stat_branches_o;
  logic [STAT_W-1:0] stat_mispredicts_o;
  modport master (
    output pred_pc_i, resolve_valid_i, is_b_type_ctl_i, instr_func3_ctl_i,
           resolve_pc_i, pred_taken_i, opr_a_i, opr_b_i,
    input  pred_taken_o, branch_taken_o, mispredict_o, resolve_valid_o,
           illegal_func3_o, stat_branches_o, stat_mispredicts_o
  );
  modport slave (
    input  pred_pc_i, resolve_valid_i, is_b_type_ctl_i, instr_func3_ctl_i,
           resolve_pc_i, pred_taken_i, opr_a_i, opr_b_i,
    output pred_taken_o, branch_taken_o, mispredict_o, resolve_valid_o,
           illegal_func3_o, stat_branches_o, stat_mispredicts_o
  );
endinterface

// File: rtl/branch_unit_bht.sv
// branch_unit_bht: RV32I branch resolution with a 2-bit saturating-counter BHT and perf stats
// Ports: clk, reset_n (async active-low), bus (branch_unit_bht_if.slave):
//   fetch:   pred_pc_i -> pred_taken_o (combinational table lookup)
//   execute: resolve_valid_i, is_b_type_ctl_i, instr_func3_ctl_i, resolve_pc_i, pred_taken_i,
//            opr_a_i, opr_b_i -> branch_taken_o, mispredict_o, resolve_valid_o, illegal_func3_o
//            (registered single-cycle pulses)
//   stats:   stat_branches_o, stat_mispredicts_o (saturating counters)
module branch_unit_bht #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int STAT_W      = 32
) (
  input logic              clk,
  input logic              reset_n,
  branch_unit_bht_if.slave bus
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);
  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] pidx, ridx;
  logic             br, illegal, eq, lt, ltu, taken, wr;
  logic [1:0]       cnt, nxt;
  assign pidx = bus.pred_pc_i[IDX_W+1:2];
  assign ridx = bus.resolve_pc_i[IDX_W+1:2];
  assign bus.pred_taken_o = bht[pidx][1];
  // PC bits outside the index only exist for the full-width interface
  logic unused_pc;
  assign unused_pc = ^{bus.pred_pc_i[XLEN-1:IDX_W+2], bus.pred_pc_i[1:0],
                       bus.resolve_pc_i[XLEN-1:IDX_W+2], bus.resolve_pc_i[1:0]};
  // func3[2:1] picks the compare (00 eq, 10 signed lt, 11 unsigned lt, 01 illegal);
  // func3[0] inverts it (BNE/BGE/BGEU)
  always_comb begin
    br      = bus.resolve_valid_i & bus.is_b_type_ctl_i;
    illegal = bus.instr_func3_ctl_i[2:1] == 2'b01;
    eq      = bus.opr_a_i == bus.opr_b_i;
    lt      = $signed(bus.opr_a_i) < $signed(bus.opr_b_i);
    ltu     = bus.opr_a_i < bus.opr_b_i;
    taken   = illegal ? 1'b0 :
              (bus.instr_func3_ctl_i[2] ? (bus.instr_func3_ctl_i[1] ? ltu : lt) : eq) ^ bus.instr_func3_ctl_i[0];
    wr      = br & ~illegal;
    cnt     = bht[ridx];
    nxt     = taken ? (&cnt ? cnt : cnt + 2'd1) : (|cnt ? cnt - 2'd1 : cnt);
  end
  // Table resets to weakly-not-taken; a same-cycle lookup sees the pre-write value
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    else if (wr)
      bht[ridx] <= nxt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bus.branch_taken_o     <= 1'b0;
      bus.mispredict_o       <= 1'b0;
      bus.resolve_valid_o    <= 1'b0;
      bus.illegal_func3_o    <= 1'b0;
      bus.stat_branches_o    <= '0;
      bus.stat_mispredicts_o <= '0;
    end else begin
      bus.branch_taken_o  <= br & taken;
      bus.mispredict_o    <= br & (taken ^ bus.pred_taken_i);
      bus.resolve_valid_o <= br;
      bus.illegal_func3_o <= br & illegal;
      if (br && !(&bus.stat_branches_o))
        bus.stat_branches_o <= bus.stat_branches_o + 1'b1;
      if (br && (taken ^ bus.pred_taken_i) && !(&bus.stat_mispredicts_o))
        bus.stat_mispredicts_o <= bus.stat_mispredicts_o + 1'b1;
    end
endmodule

// File: tb/tb_branch_unit_bht.sv
// tb_branch_unit_bht: directed scoreboard bench for branch_unit_bht (STAT_W=4 to reach saturation)
module tb_branch_unit_bht;
  localparam int XLEN = 32;
  localparam int ENT  = 64;
  localparam int SW   = 4;
  typedef struct packed {logic taken; logic misp; logic ill;} exp_t;
  logic clk = 1'b0;
  logic reset_n;
  int checks = 0;
  int errors = 0;
  exp_t sbq[$];
  logic [1:0] m_bht [ENT];
  int m_br, m_mp;
  int mp_before;
  branch_unit_bht_if #(.XLEN(XLEN), .STAT_W(SW)) bus();
  branch_unit_bht #(.XLEN(XLEN), .BHT_ENTRIES(ENT), .STAT_W(SW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic int idx(input logic [31:0] pc);
    return int'((pc >> 2) & (ENT - 1));
  endfunction
  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < ENT; i++) m_bht[i] = 2'b01;
    m_br = 0;
    m_mp = 0;
  endtask
  task automatic check_idle_outputs(input string tag);
    chk({tag, "_taken"}, bus.branch_taken_o, 0);
    chk({tag, "_misp"}, bus.mispredict_o, 0);
    chk({tag, "_valid"}, bus.resolve_valid_o, 0);
    chk({tag, "_ill"}, bus.illegal_func3_o, 0);
    chk({tag, "_stat_br"}, bus.stat_branches_o, m_br);
    chk({tag, "_stat_mp"}, bus.stat_mispredicts_o, m_mp);
  endtask
  // Called at a negedge: drives one branch, checks the same-cycle lookup, then the registered result
  task automatic resolve(input string tag, input logic [31:0] pc, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic pred);
    exp_t e;
    logic t, ill;
    bus.resolve_valid_i   = 1'b1;
    bus.is_b_type_ctl_i   = 1'b1;
    bus.instr_func3_ctl_i = f3;
    bus.resolve_pc_i      = pc;
    bus.opr_a_i           = a;
    bus.opr_b_i           = b;
    bus.pred_taken_i      = pred;
    #1;
    chk({tag, "_pred_pre"}, bus.pred_taken_o, m_bht[idx(bus.pred_pc_i)][1]);
    t   = ref_taken(f3, a, b);
    ill = (f3 == 3'b010) || (f3 == 3'b011);
    sbq.push_back('{taken: t, misp: t ^ pred, ill: ill});
    if (!ill) m_bht[idx(pc)] = t ? (m_bht[idx(pc)] == 2'b11 ? 2'b11 : m_bht[idx(pc)] + 2'b01)
                                 : (m_bht[idx(pc)] == 2'b00 ? 2'b00 : m_bht[idx(pc)] - 2'b01);
    m_br = (m_br == 15) ? 15 : m_br + 1;
    if (t ^ pred) m_mp = (m_mp == 15) ? 15 : m_mp + 1;
    @(posedge clk);
    @(negedge clk);
    bus.resolve_valid_i = 1'b0;
    bus.is_b_type_ctl_i = 1'b0;
    e = sbq.pop_front();
    chk({tag, "_taken"}, bus.branch_taken_o, e.taken);
    chk({tag, "_misp"}, bus.mispredict_o, e.misp);
    chk({tag, "_valid"}, bus.resolve_valid_o, 1);
    chk({tag, "_ill"}, bus.illegal_func3_o, e.ill);
    chk({tag, "_stat_br"}, bus.stat_branches_o, m_br);
    chk({tag, "_stat_mp"}, bus.stat_mispredicts_o, m_mp);
    #1;
    chk({tag, "_pred_post"}, bus.pred_taken_o, m_bht[idx(bus.pred_pc_i)][1]);
  endtask
  task automatic check_all_preds(input string tag);
    for (int i = 0; i < ENT; i++) begin
      bus.pred_pc_i = 32'(i * 4);
      #1;
      chk(tag, bus.pred_taken_o, 0);
    end
  endtask
  initial begin
    reset_n               = 1'b0;
    bus.pred_pc_i         = '0;
    bus.resolve_valid_i   = 1'b0;
    bus.is_b_type_ctl_i   = 1'b0;
    bus.instr_func3_ctl_i = '0;
    bus.resolve_pc_i      = '0;
    bus.pred_taken_i      = 1'b0;
    bus.opr_a_i           = '0;
    bus.opr_b_i           = '0;
    model_reset();
    #1;
    check_idle_outputs("por");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    // compare semantics
    bus.pred_pc_i = 32'h8;
    resolve("blt",  32'h08, 3'b100, 32'hFFFF_FFFF, 32'd1, 1'b0);
    chk("blt_spec", bus.branch_taken_o, 1);
    resolve("bltu", 32'h0C, 3'b110, 32'hFFFF_FFFF, 32'd1, 1'b0);
    chk("bltu_spec", bus.branch_taken_o, 0);
    resolve("bge",  32'h10, 3'b101, 32'hFFFF_FFFF, 32'd1, 1'b0);
    chk("bge_spec", bus.branch_taken_o, 0);
    resolve("bgeu", 32'h14, 3'b111, 32'hFFFF_FFFF, 32'd1, 1'b0);
    chk("bgeu_spec", bus.branch_taken_o, 1);
    resolve("beq",  32'h18, 3'b000, 32'd5, 32'd5, 1'b0);
    chk("beq_spec", bus.branch_taken_o, 1);
    resolve("bne",  32'h1C, 3'b001, 32'd5, 32'd5, 1'b1);
    chk("bne_spec", bus.branch_taken_o, 0);
    resolve("blt_eq", 32'h20, 3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
    // training at 0x100
    bus.pred_pc_i = 32'h100;
    mp_before = m_mp;
    resolve("train1", 32'h100, 3'b000, 32'd3, 32'd3, 1'b0);
    chk("train1_pred_spec", bus.pred_taken_o, 1);
    resolve("train2", 32'h100, 3'b000, 32'd3, 32'd3, 1'b0);
    resolve("train3", 32'h100, 3'b000, 32'd3, 32'd3, 1'b0);
    chk("train_mp_delta", 32'(bus.stat_mispredicts_o) - 32'(mp_before), 3);
    // same-cycle collision at 0x40: old counter 01 seen, new value next cycle
    bus.pred_pc_i = 32'h40;
    resolve("collide", 32'h40, 3'b000, 32'd1, 32'd1, 1'b0);
    chk("collide_after", bus.pred_taken_o, 1);
    // aliasing and illegal func3: 0x100 + 4*ENT shares the trained counter
    bus.pred_pc_i = 32'h100 + 4 * ENT;
    #1;
    chk("alias_pred", bus.pred_taken_o, 1);
    resolve("illegal", 32'h100 + 4 * ENT, 3'b010, 32'd9, 32'd9, 1'b1);
    chk("illegal_spec", bus.illegal_func3_o, 1);
    resolve("illegal011", 32'h100 + 4 * ENT, 3'b011, 32'd0, 32'd0, 1'b0);
    resolve("alias_nt1", 32'h100 + 4 * ENT, 3'b001, 32'd7, 32'd7, 1'b0);
    resolve("alias_nt2", 32'h100 + 4 * ENT, 3'b001, 32'd7, 32'd7, 1'b0);
    bus.pred_pc_i = 32'h100;
    #1;
    chk("alias_back", bus.pred_taken_o, 0);
    // valid but not a branch, with garbage operands: no state change
    @(negedge clk);
    bus.resolve_valid_i   = 1'b1;
    bus.is_b_type_ctl_i   = 1'b0;
    bus.instr_func3_ctl_i = 3'($urandom);
    bus.opr_a_i           = $urandom;
    bus.opr_b_i           = $urandom;
    bus.pred_taken_i      = 1'b1;
    bus.resolve_pc_i      = 32'h100;
    @(posedge clk);
    @(negedge clk);
    bus.resolve_valid_i = 1'b0;
    check_idle_outputs("nonbranch");
    // saturation of 4-bit stats
    bus.pred_pc_i = 32'h80;
    for (int i = 0; i < 20; i++) resolve("sat", 32'h80, 3'b110, 32'd1, 32'd2, 1'b0);
    chk("sat_br_spec", bus.stat_branches_o, 4'hF);
    chk("sat_mp_spec", bus.stat_mispredicts_o, 4'hF);
    // asynchronous reset while outputs are high and a branch is in flight
    bus.resolve_valid_i   = 1'b1;
    bus.is_b_type_ctl_i   = 1'b1;
    bus.instr_func3_ctl_i = 3'b000;
    bus.opr_a_i           = 32'd1;
    bus.opr_b_i           = 32'd1;
    bus.pred_taken_i      = 1'b0;
    bus.resolve_pc_i      = 32'h40;
    @(posedge clk);
    #1;
    chk("pre_reset_valid", bus.resolve_valid_o, 1);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_idle_outputs("async_rst");
    check_all_preds("rst_pred");
    @(negedge clk);
    bus.resolve_valid_i = 1'b0;
    bus.is_b_type_ctl_i = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_rst");
    bus.pred_pc_i = 32'h40;
    resolve("first_after_rst", 32'h40, 3'b101, 32'd4, 32'd2, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
